// File: rtl/shift_pkg.sv
// Shared op encodings for the shift/rotate execute path.
package shift_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROR = 2'b11;

endpackage

// File: rtl/shift_core.sv
// Purpose: combinational log shifter/rotator (SLL, SRL, SRA, ROR), one mux level per amount bit.
// Latency: 0 cycles. Backpressure: none, pure logic.
module shift_core
  import shift_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SAW = 4
) (
  input  logic [1:0]     op,
  input  logic [DW-1:0]  data,
  input  logic [SAW-1:0] amt,
  output logic [DW-1:0]  res
);

  logic [DW-1:0] lvl [SAW+1];

  assign lvl[0] = data;

  for (genvar k = 0; k < SAW; k++) begin : g_lvl
    localparam int SH = 1 << k;
    logic [DW-1:0] x;
    logic [DW-1:0] sll_v, srl_v, sra_v, ror_v;

    assign x     = lvl[k];
    assign sll_v = {x[DW-SH-1:0], {SH{1'b0}}};
    assign srl_v = {{SH{1'b0}}, x[DW-1:SH]};
    // Sign bit comes from the original operand MSB, which every SRA level preserves.
    assign sra_v = {{SH{x[DW-1]}}, x[DW-1:SH]};
    assign ror_v = {x[SH-1:0], x[DW-1:SH]};

    assign lvl[k+1] = !amt[k]        ? x     :
                      (op == OP_SLL) ? sll_v :
                      (op == OP_SRL) ? srl_v :
                      (op == OP_SRA) ? sra_v : ror_v;
  end

  assign res = lvl[SAW];

endmodule

// File: rtl/shift_ex_stage.sv
// Purpose: two-stage shift/rotate execute stage; optional SHIFT_FLAGS_EN adds registered out_z/out_n.
// Latency: op accepted at edge N appears on out_* after edge N+1.
// Backpressure: out_ready low holds S2, then S1; in_ready drops only when both are full.
module shift_ex_stage
  import shift_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SAW  = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [DW-1:0]   in_data,
  input  logic [SAW-1:0]  in_amt,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [TAGW-1:0] out_tag,
`ifdef SHIFT_FLAGS_EN
  output logic            out_z,
  output logic            out_n,
`endif
  output logic            fwd_valid,
  output logic [TAGW-1:0] fwd_tag
);

  logic            s1_valid;
  shift_op_t       s1_op;
  logic [DW-1:0]   s1_data;
  logic [SAW-1:0]  s1_amt;
  logic [TAGW-1:0] s1_tag;

  logic            s2_valid;
  logic [DW-1:0]   s2_data;
  logic [TAGW-1:0] s2_tag;

  logic [DW-1:0]   core_res;
  logic            s2_adv;
  logic            accept;

  shift_core #(.DW(DW), .SAW(SAW)) u_core (
    .op   (s1_op),
    .data (s1_data),
    .amt  (s1_amt),
    .res  (core_res)
  );

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Flush wins over accept and advance; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_SLL;
      s1_data  <= '0;
      s1_amt   <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= core_res;
          s2_tag  <= s1_tag;
        end
      end
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_op   <= in_op;
        s1_data <= in_data;
        s1_amt  <= in_amt;
        s1_tag  <= in_tag;
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic s2_z;
  logic s2_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_z <= 1'b0;
      s2_n <= 1'b0;
    end else if (!flush && s2_adv && s1_valid) begin
      s2_z <= (core_res == '0);
      s2_n <= core_res[DW-1];
    end
  end

  assign out_z = s2_z;
  assign out_n = s2_n;
`endif

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign fwd_valid = s1_valid;
  assign fwd_tag   = s1_tag;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed, table-driven bench for shift_ex_stage plus hand-written stall/flush/reset sequences.
module tb_shift_ex_stage;
  import shift_pkg::*;

  localparam int DW = 16, SAW = 4, TAGW = 4, NV = 17;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_valid;
  logic [1:0]      in_op;
  logic [DW-1:0]   in_data, out_data;
  logic [SAW-1:0]  in_amt;
  logic [TAGW-1:0] in_tag, out_tag, fwd_tag;
`ifdef SHIFT_FLAGS_EN
  logic            out_z, out_n;
`endif

  always #5 clk = ~clk;

  shift_ex_stage #(.DW(DW), .SAW(SAW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
`ifdef SHIFT_FLAGS_EN
    .out_z(out_z), .out_n(out_n),
`endif
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag)
  );

  typedef struct {
    logic [1:0]     op;
    logic [DW-1:0]  data;
    logic [SAW-1:0] amt;
    logic [DW-1:0]  exp;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [TAGW-1:0] tag);
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_data  = vecs[i].data;
    in_amt   = vecs[i].amt;
    in_tag   = tag;
  endtask

  initial begin
    vecs[0]  = '{OP_SLL, 16'h00F1, 4'd4,  16'h0F10};
    vecs[1]  = '{OP_SRA, 16'h8000, 4'd15, 16'hFFFF};
    vecs[2]  = '{OP_SRL, 16'h8000, 4'd15, 16'h0001};
    vecs[3]  = '{OP_ROR, 16'h0001, 4'd1,  16'h8000};
    vecs[4]  = '{OP_SLL, 16'h1234, 4'd0,  16'h1234};
    vecs[5]  = '{OP_SRL, 16'hABCD, 4'd0,  16'hABCD};
    vecs[6]  = '{OP_SRA, 16'h8001, 4'd0,  16'h8001};
    vecs[7]  = '{OP_ROR, 16'hBEEF, 4'd0,  16'hBEEF};
    vecs[8]  = '{OP_SRA, 16'h7F00, 4'd4,  16'h07F0};
    vecs[9]  = '{OP_SRA, 16'hF0F0, 4'd8,  16'hFFF0};
    vecs[10] = '{OP_ROR, 16'h1234, 4'd4,  16'h4123};
    vecs[11] = '{OP_ROR, 16'h8001, 4'd15, 16'h0003};
    vecs[12] = '{OP_SLL, 16'h0001, 4'd15, 16'h8000};
    vecs[13] = '{OP_SRL, 16'h1234, 4'd5,  16'h0091};
    vecs[14] = '{OP_SLL, 16'hFFFF, 4'd1,  16'hFFFE};
    vecs[15] = '{OP_SRA, 16'h4000, 4'd14, 16'h0001};
    vecs[16] = '{OP_SRL, 16'h0001, 4'd1,  16'h0000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_SLL; in_data = '0; in_amt = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // One op at a time: S1 visible on the forwarding taps, result one edge later.
    for (int i = 0; i < NV; i++) begin
      drive(i, TAGW'(i));
      tick();
      check($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'd1);
      check($sformatf("v%0d_fwd_tag", i),   32'(fwd_tag),   32'(i % 16));
      check($sformatf("v%0d_early", i),     32'(out_valid), 32'd0);
      in_valid = 1'b0;
      tick();
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].exp));
      check($sformatf("v%0d_out_tag", i),   32'(out_tag),   32'(i % 16));
`ifdef SHIFT_FLAGS_EN
      check($sformatf("v%0d_out_z", i), 32'(out_z), 32'(vecs[i].exp == 16'h0000));
      check($sformatf("v%0d_out_n", i), 32'(out_n), 32'(vecs[i].exp[15]));
`endif
    end
    tick();

    // Back-to-back stream of 8 ops, one result per cycle, in order.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(i, TAGW'(i + 8));
        check($sformatf("bb%0d_in_ready", i), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check($sformatf("bb%0d_out_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("bb%0d_out_data", i),  32'(out_data),  32'(vecs[i-1].exp));
        check($sformatf("bb%0d_out_tag", i),   32'(out_tag),   32'(i + 7));
      end
    end
    tick();
    check("bb_drained", 32'(out_valid), 32'd0);

    // Back-pressure: out_ready low for 5 cycles while 3 ops are offered.
    out_ready = 1'b0;
    drive(0, 4'd1);  tick();
    drive(10, 4'd2); tick();
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    drive(13, 4'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_out_data", c),  32'(out_data),  32'h0F10);
      check($sformatf("bp%0d_out_tag", c),   32'(out_tag),   32'd1);
      check($sformatf("bp%0d_fwd_tag", c),   32'(fwd_tag),   32'd2);
      check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_drain1_data", 32'(out_data), 32'h4123);
    check("bp_drain1_tag",  32'(out_tag),  32'd2);
    check("bp_third_in_s1", 32'(fwd_tag),  32'd3);
    tick();
    check("bp_drain2_data", 32'(out_data), 32'h0091);
    check("bp_drain2_tag",  32'(out_tag),  32'd3);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with both stages full and a new op offered: everything is squashed.
    out_ready = 1'b0;
    drive(1, 4'd4); tick();
    drive(2, 4'd5); tick();
    drive(3, 4'd6);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();
    check("fl_op_lost", 32'(out_valid), 32'd0);

    // Synchronous reset mid-stream.
    drive(8, 4'd7); tick();
    drive(9, 4'd8); tick();
    check("rs_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    drive(14, 4'd9);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_out_data",  32'(out_data),  32'd0);
    check("rs_out_tag",   32'(out_tag),   32'd0);
    check("rs_fwd_valid", 32'(fwd_valid), 32'd0);
`ifdef SHIFT_FLAGS_EN
    check("rs_out_z", 32'(out_z), 32'd0);
    check("rs_out_n", 32'(out_n), 32'd0);
`endif
    tick();
    check("rs_stays_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
